// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// reg_scoreboard : shadow rd-tag pipeline (X/M/W) driving the decode interlock
//                  and the pending-write register mask.
// Revision       : 1.0
// ============================================================================
module reg_scoreboard #(
  parameter bit FWD_EN   = 1'b1,
  parameter bit W_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_D,
  input  logic        valid_D,
  input  logic        RegWEn_D,
  input  logic        mem_busy,
  input  logic        flush_X,
  output logic        stall_D,
  output logic        bubble_X,
  output logic [31:0] pending_mask
);

  localparam logic [6:0] C_OP_LOAD   = 7'h03;
  localparam logic [6:0] C_OP_LUI    = 7'h37;
  localparam logic [6:0] C_OP_AUIPC  = 7'h17;
  localparam logic [6:0] C_OP_JAL    = 7'h6F;
  localparam logic [6:0] C_OP_RTYPE  = 7'h33;
  localparam logic [6:0] C_OP_STORE  = 7'h23;
  localparam logic [6:0] C_OP_BRANCH = 7'h63;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } entry_t;

  localparam entry_t C_EMPTY = '0;

  entry_t ex_q, ex_d;
  entry_t em_q, em_d;
  entry_t ew_q, ew_d;
  logic   flush_pend_q, flush_pend_d;

  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use_rs1;
  logic       w_use_rs2;
  entry_t     w_dec;
  logic       w_hz_x;
  logic       w_hz_m;
  logic       w_hz_w;
  logic       w_hazard;
  logic       w_advance;
  logic       w_kill;
  logic       w_bubble;
  logic       w_unused;

  assign w_opcode = instr_D[6:0];
  assign w_rd     = instr_D[11:7];
  assign w_rs1    = instr_D[19:15];
  assign w_rs2    = instr_D[24:20];
  assign w_unused = ^{instr_D[31:25], instr_D[14:12]};

  assign w_use_rs1 = !((w_opcode == C_OP_LUI) || (w_opcode == C_OP_AUIPC) ||
                       (w_opcode == C_OP_JAL));
  assign w_use_rs2 = (w_opcode == C_OP_RTYPE) || (w_opcode == C_OP_STORE) ||
                     (w_opcode == C_OP_BRANCH);

  always_comb begin
    w_dec    = C_EMPTY;
    w_dec.v  = 1'b1;
    w_dec.rd = w_rd;
    w_dec.we = RegWEn_D && (w_rd != 5'd0);
    w_dec.ld = (w_opcode == C_OP_LOAD);
  end

  // A source matches an entry only if it is read, non-x0, and the entry writes it.
  function automatic logic src_hit(input entry_t e, input logic [4:0] rs, input logic used);
    return used && (rs != 5'd0) && e.v && e.we && (e.rd == rs);
  endfunction

  always_comb begin
    w_hz_x = (src_hit(ex_q, w_rs1, w_use_rs1) || src_hit(ex_q, w_rs2, w_use_rs2)) &&
             (!FWD_EN || ex_q.ld);
    w_hz_m = !FWD_EN &&
             (src_hit(em_q, w_rs1, w_use_rs1) || src_hit(em_q, w_rs2, w_use_rs2));
    w_hz_w = !FWD_EN && !W_BYPASS &&
             (src_hit(ew_q, w_rs1, w_use_rs1) || src_hit(ew_q, w_rs2, w_use_rs2));
  end

  assign w_hazard  = valid_D && (w_hz_x || w_hz_m || w_hz_w);
  assign w_advance = !mem_busy;
  assign w_kill    = flush_X || flush_pend_q;
  assign w_bubble  = w_advance && (w_kill || !valid_D || w_hazard);

  // Reset forces a safe decode view regardless of the live inputs.
  assign stall_D  = !rst && (mem_busy || w_hazard);
  assign bubble_X = rst || w_bubble;

  always_comb begin
    ex_d         = ex_q;
    em_d         = em_q;
    ew_d         = ew_q;
    flush_pend_d = flush_pend_q;
    if (w_advance) begin
      ew_d         = em_q;
      em_d         = ex_q;
      ex_d         = w_bubble ? C_EMPTY : w_dec;
      flush_pend_d = 1'b0;
    end else if (flush_X) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q         <= C_EMPTY;
      em_q         <= C_EMPTY;
      ew_q         <= C_EMPTY;
      flush_pend_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      em_q         <= em_d;
      ew_q         <= ew_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    if (ex_q.v && ex_q.we) pending_mask[ex_q.rd] = 1'b1;
    if (em_q.v && em_q.we) pending_mask[em_q.rd] = 1'b1;
    if (ew_q.v && ew_q.we) pending_mask[ew_q.rd] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule
`default_nettype wire
